// File: rtl/vga_text_pkg.sv
// vga_text_pkg: grid geometry, character codes, control-word layout and FSM types for vga_text_writer.
package vga_text_pkg;
    localparam int COLS = 32;
    localparam int ROWS = 16;
    localparam int PAD_W = 16;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_PRINT_LO = 8'h20;
    localparam logic [7:0] CH_PRINT_HI = 8'h7E;
    localparam int FONT_LSB = 0;
    localparam int COLOR_LSB = 7;
    typedef enum logic [1:0] {IDLE, WRITE, CLR_ROW, CLR_SCR} vga_text_state_t;
    typedef enum logic [2:0] {OP_NONE, OP_INC, OP_NL, OP_CR, OP_BS, OP_HOME} cur_op_t;
    function automatic logic [31:0] mk_ctrl(input logic [8:0] color, input logic [6:0] font);
        return {{PAD_W{1'b0}}, 16'(color) << (COLOR_LSB - 7), 7'h0} | (32'(font) << FONT_LSB);
    endfunction
endpackage

// File: rtl/vga_text_writer_if.sv
// vga_text_writer_if: character byte stream in, single-cycle text-buffer write port out.
interface vga_text_writer_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [8:0]  in_color;
    logic [3:0]  vga_addr_v;
    logic [4:0]  vga_addr_h;
    logic [31:0] vga_ctrl;
    logic        vga_ctrl_en;
    modport slave (input in_valid, in_data, in_color, output in_ready, vga_addr_v, vga_addr_h, vga_ctrl, vga_ctrl_en);
    modport master (output in_valid, in_data, in_color, input in_ready, vga_addr_v, vga_addr_h, vga_ctrl, vga_ctrl_en);
endinterface

// File: rtl/vga_text_cursor.sv
// vga_text_cursor: row/column cursor with increment, newline, CR, backspace and home; both counters wrap modulo width.
module vga_text_cursor
    import vga_text_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  cur_op_t    op,
    output logic [3:0] cur_v,
    output logic [4:0] cur_h,
    output logic       at_eol
);
    logic [3:0] v_q, v_d;
    logic [4:0] h_q, h_d;
    assign at_eol = h_q == 5'(COLS - 1);
    assign cur_v = v_q;
    assign cur_h = h_q;
    always_comb begin
        v_d = v_q;
        h_d = h_q;
        case (op)
            OP_INC: begin
                v_d = at_eol ? v_q + 4'd1 : v_q;
                h_d = h_q + 5'd1;
            end
            OP_NL: begin
                v_d = v_q + 4'd1;
                h_d = 5'd0;
            end
            OP_CR: h_d = 5'd0;
            OP_BS: h_d = h_q - 5'd1;
            OP_HOME: begin
                v_d = 4'd0;
                h_d = 5'd0;
            end
            default: ;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= 4'd0;
            h_q <= 5'd0;
        end else begin
            v_q <= v_d;
            h_q <= h_d;
        end
    end
endmodule

// File: rtl/vga_text_writer.sv
// vga_text_writer: byte stream to VGA text-buffer writer with control characters, wrap and screen clear.
// Define VGA_TEXT_LINECLR_EN to blank each new row (CLR_ROW) on LF or column wrap.
module vga_text_writer
    import vga_text_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    vga_text_writer_if.slave bus,
    output logic [3:0] cur_v,
    output logic [4:0] cur_h,
    output logic       busy
);
`ifdef VGA_TEXT_LINECLR_EN
    localparam bit LINECLR = 1'b1;
`else
    localparam bit LINECLR = 1'b0;
`endif
    vga_text_state_t state_q, state_d;
    logic        en_q, en_d, rdy_q, rdy_d, busy_q, busy_d, bs_q, bs_d;
    logic [3:0]  v_q, v_d;
    logic [4:0]  h_q, h_d;
    logic [31:0] ctrl_q, ctrl_d;
    cur_op_t     op;
    logic        at_eol, acc, printable, done_scr;
    assign acc = bus.in_valid & rdy_q;
    assign printable = bus.in_data >= CH_PRINT_LO && bus.in_data <= CH_PRINT_HI;
    assign done_scr = &{v_q, h_q};
    vga_text_cursor u_cursor (.clk(clk), .rst(rst), .op(op), .cur_v(cur_v), .cur_h(cur_h), .at_eol(at_eol));
    // The address registers double as the clear-sequence counters.
    always_comb begin
        state_d = state_q;
        en_d = 1'b0;
        v_d = v_q;
        h_d = h_q;
        ctrl_d = ctrl_q;
        bs_d = bs_q;
        op = OP_NONE;
        case (state_q)
            IDLE: if (acc) begin
                if (printable) begin
                    state_d = WRITE;
                    en_d = 1'b1;
                    v_d = cur_v;
                    h_d = cur_h;
                    ctrl_d = mk_ctrl(bus.in_color, bus.in_data[6:0]);
                    bs_d = 1'b0;
                end else if (bus.in_data == CH_LF) begin
                    op = OP_NL;
                    if (LINECLR) begin
                        state_d = CLR_ROW;
                        en_d = 1'b1;
                        v_d = cur_v + 4'd1;
                        h_d = 5'd0;
                        ctrl_d = mk_ctrl(bus.in_color, CH_SPACE[6:0]);
                    end
                end else if (bus.in_data == CH_CR) begin
                    op = OP_CR;
                end else if (bus.in_data == CH_BS && cur_h != 5'd0) begin
                    state_d = WRITE;
                    en_d = 1'b1;
                    v_d = cur_v;
                    h_d = cur_h - 5'd1;
                    ctrl_d = mk_ctrl(bus.in_color, CH_SPACE[6:0]);
                    bs_d = 1'b1;
                end else if (bus.in_data == CH_FF) begin
                    state_d = CLR_SCR;
                    en_d = 1'b1;
                    v_d = 4'd0;
                    h_d = 5'd0;
                    ctrl_d = mk_ctrl(bus.in_color, CH_SPACE[6:0]);
                end
            end
            WRITE: begin
                op = bs_q ? OP_BS : OP_INC;
                state_d = IDLE;
                if (LINECLR && !bs_q && at_eol) begin
                    state_d = CLR_ROW;
                    en_d = 1'b1;
                    v_d = cur_v + 4'd1;
                    h_d = 5'd0;
                    ctrl_d = mk_ctrl(ctrl_q[COLOR_LSB +: 9], CH_SPACE[6:0]);
                end
            end
            CLR_ROW: begin
                en_d = h_q != 5'(COLS - 1);
                state_d = en_d ? CLR_ROW : IDLE;
                h_d = en_d ? h_q + 5'd1 : h_q;
            end
            CLR_SCR: begin
                en_d = !done_scr;
                state_d = done_scr ? IDLE : CLR_SCR;
                {v_d, h_d} = done_scr ? {v_q, h_q} : {v_q, h_q} + 9'd1;
                op = done_scr ? OP_HOME : OP_NONE;
            end
            default: state_d = IDLE;
        endcase
        rdy_d = state_d == IDLE;
        busy_d = state_d != IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            en_q <= 1'b0;
            rdy_q <= 1'b0;
            busy_q <= 1'b0;
            bs_q <= 1'b0;
            v_q <= 4'd0;
            h_q <= 5'd0;
            ctrl_q <= 32'd0;
        end else begin
            state_q <= state_d;
            en_q <= en_d;
            rdy_q <= rdy_d;
            busy_q <= busy_d;
            bs_q <= bs_d;
            v_q <= v_d;
            h_q <= h_d;
            ctrl_q <= ctrl_d;
        end
    end
    assign bus.in_ready = rdy_q;
    assign bus.vga_ctrl_en = en_q;
    assign bus.vga_addr_v = v_q;
    assign bus.vga_addr_h = h_q;
    assign bus.vga_ctrl = ctrl_q;
    assign busy = busy_q;
endmodule

// File: tb/tb_vga_text_writer.sv
// tb_vga_text_writer: directed vector table plus hand sequences for wrap, LF, BS, screen clear and reset abort.
module tb_vga_text_writer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] cur_v;
    logic [4:0] cur_h;
    logic busy;
    vga_text_writer_if bus();
    vga_text_writer dut (.clk(clk), .rst(rst), .bus(bus), .cur_v(cur_v), .cur_h(cur_h), .busy(busy));
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_strb = 0;
    logic [3:0] last_v;
    logic [4:0] last_h;
    logic [31:0] last_ctrl;
    logic s_en, s_rdy;
    logic [3:0] s_v;
    logic [4:0] s_h;
    logic [31:0] s_ctrl;

    always @(negedge clk) if (bus.vga_ctrl_en) begin
        n_strb++;
        last_v = bus.vga_addr_v;
        last_h = bus.vga_addr_h;
        last_ctrl = bus.vga_ctrl;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        while (!bus.in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) chk({nm, "_ready_timeout"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic send(input logic [7:0] d, input logic [8:0] c);
        wait_ready("send");
        bus.in_valid = 1'b1;
        bus.in_data = d;
        bus.in_color = c;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data = 8'h0C;
        s_en = bus.vga_ctrl_en;
        s_rdy = bus.in_ready;
        s_v = bus.vga_addr_v;
        s_h = bus.vga_addr_h;
        s_ctrl = bus.vga_ctrl;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0] d;
        logic [8:0] c;
        logic en;
        logic [3:0] v;
        logic [4:0] h;
        logic [31:0] ctrl;
        logic [3:0] cv;
        logic [4:0] ch;
    } vec_t;
    vec_t tbl[12];

    initial begin
        int n0;
        int bad;
        tbl[0]  = '{8'h41, 9'h1FF, 1'b1, 4'd0, 5'd0, 32'h0000FFC1, 4'd0, 5'd1};
        tbl[1]  = '{8'h42, 9'h003, 1'b1, 4'd0, 5'd1, 32'h000001C2, 4'd0, 5'd2};
        tbl[2]  = '{8'h0D, 9'h000, 1'b0, 4'd0, 5'd0, 32'h0,        4'd0, 5'd0};
        tbl[3]  = '{8'h7E, 9'h100, 1'b1, 4'd0, 5'd0, 32'h0000807E, 4'd0, 5'd1};
        tbl[4]  = '{8'h0A, 9'h000, 1'b0, 4'd0, 5'd0, 32'h0,        4'd1, 5'd0};
        tbl[5]  = '{8'h08, 9'h000, 1'b0, 4'd0, 5'd0, 32'h0,        4'd1, 5'd0};
        tbl[6]  = '{8'h20, 9'h055, 1'b1, 4'd1, 5'd0, 32'h00002AA0, 4'd1, 5'd1};
        tbl[7]  = '{8'h31, 9'h000, 1'b1, 4'd1, 5'd1, 32'h00000031, 4'd1, 5'd2};
        tbl[8]  = '{8'h08, 9'h0F0, 1'b1, 4'd1, 5'd1, 32'h00007820, 4'd1, 5'd1};
        tbl[9]  = '{8'h1B, 9'h000, 1'b0, 4'd0, 5'd0, 32'h0,        4'd1, 5'd1};
        tbl[10] = '{8'hC1, 9'h000, 1'b0, 4'd0, 5'd0, 32'h0,        4'd1, 5'd1};
        tbl[11] = '{8'h7F, 9'h000, 1'b0, 4'd0, 5'd0, 32'h0,        4'd1, 5'd1};
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        bus.in_color = 9'h000;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_en", 32'(bus.vga_ctrl_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_addr", {23'd0, bus.vga_addr_v, bus.vga_addr_h}, 32'd0);
        chk("rst_ctrl", bus.vga_ctrl, 32'd0);
        chk("rst_cur", {23'd0, cur_v, cur_h}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_rst", 32'(bus.in_ready), 32'd1);

        for (int i = 0; i < 12; i++) begin
            send(tbl[i].d, tbl[i].c);
            chk($sformatf("vec%0d_en", i), 32'(s_en), 32'(tbl[i].en));
            chk($sformatf("vec%0d_ready", i), 32'(s_rdy), 32'(!tbl[i].en));
            if (tbl[i].en) begin
                chk($sformatf("vec%0d_addr", i), {23'd0, s_v, s_h}, {23'd0, tbl[i].v, tbl[i].h});
                chk($sformatf("vec%0d_ctrl", i), s_ctrl, tbl[i].ctrl);
            end
            wait_ready("vec");
            chk($sformatf("vec%0d_cur", i), {23'd0, cur_v, cur_h}, {23'd0, tbl[i].cv, tbl[i].ch});
        end

        do_reset();
        n_strb = 0;
        for (int i = 0; i < 32; i++) begin
            send(8'h41 + 8'(i), 9'h011);
            wait_ready("wrap");
        end
`ifdef VGA_TEXT_LINECLR_EN
        chk("wrap_strobes", 32'(n_strb), 32'd64);
        chk("wrap_last_addr", {23'd0, last_v, last_h}, {23'd0, 4'd1, 5'd31});
`else
        chk("wrap_strobes", 32'(n_strb), 32'd32);
        chk("wrap_last_addr", {23'd0, last_v, last_h}, {23'd0, 4'd0, 5'd31});
        chk("wrap_last_ctrl", last_ctrl, 32'h000008E0);
`endif
        chk("wrap_cur", {23'd0, cur_v, cur_h}, {23'd0, 4'd1, 5'd0});

        do_reset();
        for (int i = 0; i < 15; i++) send(8'h0A, 9'h000);
        for (int i = 0; i < 5; i++) send(8'h61, 9'h000);
        wait_ready("lf_setup");
        chk("lf_setup_cur", {23'd0, cur_v, cur_h}, {23'd0, 4'd15, 5'd5});
        n0 = n_strb;
        send(8'h0A, 9'h007);
        wait_ready("lf");
        chk("lf_row_wrap_cur", {23'd0, cur_v, cur_h}, 32'd0);
`ifdef VGA_TEXT_LINECLR_EN
        chk("lf_strobes", 32'(n_strb - n0), 32'd32);
`else
        chk("lf_strobes", 32'(n_strb - n0), 32'd0);
`endif

        do_reset();
        for (int i = 0; i < 3; i++) send(8'h0A, 9'h000);
        send(8'h08, 9'h000);
        chk("bs_col0_en", 32'(s_en), 32'd0);
        wait_ready("bs0");
        chk("bs_col0_cur", {23'd0, cur_v, cur_h}, {23'd0, 4'd3, 5'd0});
        for (int i = 0; i < 4; i++) send(8'h62, 9'h000);
        send(8'h08, 9'h001);
        chk("bs_en", 32'(s_en), 32'd1);
        chk("bs_addr", {23'd0, s_v, s_h}, {23'd0, 4'd3, 5'd3});
        chk("bs_ctrl", s_ctrl, 32'h000000A0);
        wait_ready("bs");
        chk("bs_cur", {23'd0, cur_v, cur_h}, {23'd0, 4'd3, 5'd3});

        send(8'h5A, 9'h000);
        send(8'h0C, 9'h0AA);
        chk("ff_first_en", 32'(s_en), 32'd1);
        chk("ff_first_addr", {23'd0, s_v, s_h}, 32'd0);
        chk("ff_busy", 32'(busy), 32'd1);
        bad = 0;
        for (int i = 1; i < 512; i++) begin
            @(posedge clk);
            #1;
            if (!bus.vga_ctrl_en || bus.in_ready) bad++;
        end
        chk("ff_gaps", 32'(bad), 32'd0);
        chk("ff_last_addr", {23'd0, bus.vga_addr_v, bus.vga_addr_h}, {23'd0, 4'd15, 5'd31});
        chk("ff_last_ctrl", bus.vga_ctrl, 32'h00005520);
        @(posedge clk);
        #1;
        chk("ff_end_en", 32'(bus.vga_ctrl_en), 32'd0);
        chk("ff_end_ready", 32'(bus.in_ready), 32'd1);
        chk("ff_cur", {23'd0, cur_v, cur_h}, 32'd0);

        send(8'h51, 9'h000);
        send(8'h0C, 9'h1C0);
        for (int i = 2; i <= 100; i++) begin
            @(posedge clk);
            #1;
        end
        chk("abort_pre_en", 32'(bus.vga_ctrl_en), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n0 = n_strb;
        chk("abort_en", 32'(bus.vga_ctrl_en), 32'd0);
        chk("abort_outs", {bus.vga_ctrl[22:0], bus.vga_addr_v, bus.vga_addr_h}, 32'd0);
        chk("abort_ctrl", bus.vga_ctrl, 32'd0);
        chk("abort_cur", {23'd0, cur_v, cur_h}, 32'd0);
        chk("abort_ready", 32'(bus.in_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_ready_after", 32'(bus.in_ready), 32'd1);
        chk("abort_no_strobes", 32'(n_strb - n0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
